// File: rtl/instr_fetch.sv
// Instruction fetch FSM: IDLE -> FETCH (request until ack) -> VALID (present until consumed).
// Latency: 2 cycles per instruction with a zero-wait memory; word captured on the ack edge.
// Backpressure: stall holds the presented instruction and every output; the next fetch waits for consume.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req/imem_addr                  fetch request and word-aligned address (addr always mirrors pc)
//   imem_ack/imem_rdata                 memory response, sampled only while in FETCH
//   stall, branch_taken, branch_target  downstream consume control and branch redirect
//   instr/opcode/instr_valid            presented instruction, its opcode field and valid flag
//   pc_out/pc_plus4                     address of the presented instruction and its successor
//   misalign                            sticky: a branch target with nonzero low bits was accepted
//   retired                             wrapping count of consumed instructions
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        misalign_q, misalign_d;
    logic [31:0] retired_q, retired_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        misalign_d  = misalign_q;
        retired_d   = retired_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // stall and branch_taken refer to a presented instruction; none exists here.
                if (imem_ack) begin
                    state_d  = S_VALID;
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                end
            end
            S_VALID: begin
                // imem_ack is ignored here: no request is outstanding.
                if (!stall) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + 32'd1;
                    if (branch_taken) begin
                        pc_d = {branch_target[31:2], 2'b00};
                        if (branch_target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_out_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered decodes of the next state keep imem_req/instr_valid glitch-free.
        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= 32'd0;
            misalign_q    <= 1'b0;
            retired_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
            misalign_q    <= misalign_d;
            retired_q     <= retired_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;
    assign misalign    = misalign_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] retired;
    logic [31:0] rdata_xor;

    int vectors;
    int miscompares;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .misalign      (misalign),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: fixed word at address 0, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr) ^ rdata_xor;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        rdata_xor = 32'd0;
        tick;
        tick;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        rdata_xor = 32'd0;
        #3;
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags req=%b valid=%b mis=%b expected 0/0/0", imem_req, instr_valid, misalign);
        end
        vectors++;
        if (imem_addr !== 32'd0 || instr !== 32'd0 || pc_out !== 32'd0 || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_values addr=%h instr=%h pc_out=%h retired=%h expected all 0", imem_addr, instr, pc_out, retired);
        end
        vectors++;
        if (opcode !== 6'd0 || pc_plus4 !== 32'd4) begin
            miscompares++;
            $display("FAIL reset_derived opcode=%h pc_plus4=%h expected 00/00000004", opcode, pc_plus4);
        end
    endtask

    task automatic test_first_fetch;
        do_reset;
        imem_ack = 1'b1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL first_idle imem_req=%b expected 0", imem_req);
        end
        tick;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_req req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, instr_valid);
        end
        tick;
        vectors++;
        if (instr_valid !== 1'b1 || opcode !== 6'h23 || pc_out !== 32'd0 || pc_plus4 !== 32'd4 ||
            instr !== 32'h8C01_0004 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL first_valid valid=%b op=%h pc=%h pc4=%h instr=%h req=%b expected 1/23/0/4/8c010004/0",
                     instr_valid, opcode, pc_out, pc_plus4, instr, imem_req);
        end
    endtask

    task automatic test_sequential;
        do_reset;
        imem_ack = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            vectors++;
            if (instr_valid !== ((k % 2) == 0) || imem_req !== ((k % 2) == 1)) begin
                miscompares++;
                $display("FAIL seq_cadence cycle=%0d valid=%b req=%b expected valid=%b req=%b",
                         k, instr_valid, imem_req, ((k % 2) == 0), ((k % 2) == 1));
            end
            if ((k % 2) == 1) begin
                vectors++;
                if (imem_addr !== 32'(2 * (k - 1))) begin
                    miscompares++;
                    $display("FAIL seq_addr cycle=%0d addr=%h expected %h", k, imem_addr, 32'(2 * (k - 1)));
                end
            end
        end
        vectors++;
        if (retired !== 32'd4) begin
            miscompares++;
            $display("FAIL seq_retired retired=%0d expected 4", retired);
        end
    endtask

    task automatic test_delayed_ack;
        do_reset;
        imem_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            if (k == 4) imem_ack = 1'b1;
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL delay_hold cycle=%0d req=%b addr=%h valid=%b expected 1/0/0", k, imem_req, imem_addr, instr_valid);
            end
        end
        tick;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== mem_word(32'd0) || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL delay_capture valid=%b instr=%h req=%b expected 1/%h/0", instr_valid, instr, imem_req, mem_word(32'd0));
        end
        // Acks with different data while presenting must not disturb anything.
        stall = 1'b1;
        rdata_xor = 32'hFFFF_FFFF;
        tick;
        tick;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== mem_word(32'd0) || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL stray_ack valid=%b instr=%h retired=%0d expected 1/%h/0", instr_valid, instr, retired, mem_word(32'd0));
        end
        rdata_xor = 32'd0;
    endtask

    task automatic test_stall_branch;
        do_reset;
        imem_ack = 1'b1;
        tick;
        tick;
        stall = 1'b1;
        imem_ack = 1'b0;
        branch_target = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i % 2) == 0;
            tick;
            vectors++;
            if (instr_valid !== 1'b1 || pc_out !== 32'd0 || instr !== 32'h8C01_0004 ||
                retired !== 32'd0 || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_freeze cycle=%0d valid=%b pc=%h instr=%h ret=%0d req=%b expected 1/0/8c010004/0/0",
                         i, instr_valid, pc_out, instr, retired, imem_req);
            end
        end
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0040;
        tick;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || retired !== 32'd1 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release req=%b addr=%h ret=%0d valid=%b mis=%b expected 1/40/1/0/0",
                     imem_req, imem_addr, retired, instr_valid, misalign);
        end
    endtask

    task automatic test_misalign_wrap;
        do_reset;
        imem_ack = 1'b1;
        tick;
        tick;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0042;
        tick;
        vectors++;
        if (imem_addr !== 32'h40 || misalign !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_set addr=%h mis=%b expected 40/1", imem_addr, misalign);
        end
        branch_target = 32'hFFFF_FFFC;
        tick;
        tick;
        branch_taken = 1'b0;
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFC || misalign !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_sticky addr=%h mis=%b expected fffffffc/1", imem_addr, misalign);
        end
        tick;
        vectors++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_present pc=%h pc4=%h valid=%b expected fffffffc/0/1", pc_out, pc_plus4, instr_valid);
        end
        tick;
        vectors++;
        if (imem_addr !== 32'd0 || imem_req !== 1'b1 || misalign !== 1'b1 || retired !== 32'd3) begin
            miscompares++;
            $display("FAIL wrap_fetch addr=%h req=%b mis=%b ret=%0d expected 0/1/1/3", imem_addr, imem_req, misalign, retired);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        imem_ack = 1'b1;
        tick;
        tick;
        imem_ack = 1'b0;
        tick;
        tick;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd4 || retired !== 32'd1) begin
            miscompares++;
            $display("FAIL areset_pre req=%b addr=%h ret=%0d expected 1/4/1", imem_req, imem_addr, retired);
        end
        #3 rst_n = 1'b0;
        imem_ack = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0 || retired !== 32'd0 || instr !== 32'd0 ||
            instr_valid !== 1'b0 || pc_out !== 32'd0) begin
            miscompares++;
            $display("FAIL areset_now req=%b addr=%h ret=%0d instr=%h valid=%b pc=%h expected all 0",
                     imem_req, imem_addr, retired, instr, instr_valid, pc_out);
        end
        tick;
        tick;
        #2 rst_n = 1'b1;
        tick;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_refetch req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, instr_valid);
        end
        tick;
        vectors++;
        if (instr_valid !== 1'b1 || pc_out !== 32'd0 || instr !== mem_word(32'd0)) begin
            miscompares++;
            $display("FAIL areset_capture valid=%b pc=%h instr=%h expected 1/0/%h", instr_valid, pc_out, instr, mem_word(32'd0));
        end
    endtask

    // Transaction-level model: a fetch is accepted when request meets ack, an
    // instruction is consumed when presented without stall.
    task automatic test_random;
        logic [31:0] m_pc, m_cur, m_ret;
        logic        m_mis, e_req, e_valid;
        do_reset;
        m_pc = 32'd0;
        m_cur = 32'd0;
        m_ret = 32'd0;
        m_mis = 1'b0;
        e_valid = 1'b0;
        tick;
        e_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            vectors++;
            if (imem_req !== e_req || instr_valid !== e_valid) begin
                miscompares++;
                $display("FAIL rnd_flags cycle=%0d req=%b valid=%b expected %b/%b", c, imem_req, instr_valid, e_req, e_valid);
            end
            if (e_req) begin
                vectors++;
                if (imem_addr !== m_pc) begin
                    miscompares++;
                    $display("FAIL rnd_addr cycle=%0d addr=%h expected %h", c, imem_addr, m_pc);
                end
            end
            if (e_valid) begin
                vectors++;
                if (pc_out !== m_cur || instr !== mem_word(m_cur) || pc_plus4 !== m_cur + 32'd4 ||
                    opcode !== mem_word(m_cur) >> 26) begin
                    miscompares++;
                    $display("FAIL rnd_present cycle=%0d pc=%h instr=%h pc4=%h op=%h expected pc=%h instr=%h",
                             c, pc_out, instr, pc_plus4, opcode, m_cur, mem_word(m_cur));
                end
            end
            vectors++;
            if (retired !== m_ret || misalign !== m_mis) begin
                miscompares++;
                $display("FAIL rnd_status cycle=%0d ret=%0d mis=%b expected %0d/%b", c, retired, misalign, m_ret, m_mis);
            end

            imem_ack = ($urandom_range(0, 1) == 1);
            stall = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            if ($urandom_range(0, 1) == 1) branch_target[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) branch_target = 32'hFFFF_FFFC;

            if (e_req && imem_ack) begin
                e_req = 1'b0;
                e_valid = 1'b1;
                m_cur = m_pc;
            end else if (e_valid && !stall) begin
                e_valid = 1'b0;
                e_req = 1'b1;
                m_ret = m_ret + 32'd1;
                if (branch_taken) begin
                    if (branch_target[1:0] != 2'b00) m_mis = 1'b1;
                    m_pc = branch_target & 32'hFFFF_FFFC;
                end else begin
                    m_pc = m_cur + 32'd4;
                end
            end
            tick;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_first_fetch;
        test_sequential;
        test_delayed_ack;
        test_stall_branch;
        test_misalign_wrap;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
